// File: rtl/rvv_fifo_pkg.sv
// Shared types and helpers for the RVV multi-write/multi-read uop FIFO.
// Optional checker build: define RVV_FIFO_ERR_CHK_EN.
package rvv_fifo_pkg;

   localparam int MAX_FIFO_PORTS = 4;
   localparam int LCW = $clog2(MAX_FIFO_PORTS + 1);
   localparam int DEF_DEPTH = 8;

   typedef logic [$clog2(DEF_DEPTH)-1:0]   ptr_t;
   typedef logic [$clog2(DEF_DEPTH+1)-1:0] cnt_t;
   typedef logic [LCW-1:0]                 lane_cnt_t;

   // Lanes count only while the request run from lane 0 is unbroken
   function automatic lane_cnt_t thermo_prefix_cnt(
      input logic [MAX_FIFO_PORTS-1:0] vec,
      input logic [15:0]               limit
   );
      lane_cnt_t n;
      logic      run;
      n   = '0;
      run = 1'b1;
      for (int i = 0; i < MAX_FIFO_PORTS; i++) begin
         if (run && vec[i] && (16'(i) < limit)) n = n + 1'b1;
         else run = 1'b0;
      end
      return n;
   endfunction

   function automatic logic is_thermo(
      input logic [MAX_FIFO_PORTS-1:0] vec
   );
      logic [MAX_FIFO_PORTS:0] t;
      t = {1'b0, vec};
      return ((t & (t + 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/rvv_fifo_lane_cnt.sv
// Clamps a thermometer lane request to an availability limit.
// Returns the number of lanes granted.
module rvv_fifo_lane_cnt
   import rvv_fifo_pkg::*;
#(
   parameter int N  = 2,
   parameter int LW = 4
) (
   input  logic [N-1:0]   req_i,
   input  logic [LW-1:0]  limit_i,
   output logic [LCW-1:0] cnt_o
);

   logic [MAX_FIFO_PORTS-1:0] req_w;

   assign req_w = MAX_FIFO_PORTS'(req_i);
   assign cnt_o = thermo_prefix_cnt(req_w, 16'(limit_i));

endmodule

// File: rtl/rvv_mwmr_fifo.sv
// Multi-write/multi-read show-ahead uop FIFO between dispatch and execute.
// Define RVV_FIFO_ERR_CHK_EN for sticky ovf/udf/coding error flags.
module rvv_mwmr_fifo
   import rvv_fifo_pkg::*;
#(
   parameter int DWIDTH          = 32,
   parameter int DEPTH           = 8,
   parameter int PUSH_PORTS      = 2,
   parameter int POP_PORTS       = 2,
   parameter int ALMOST_EMPTY_TH = 1,
   parameter int ALMOST_FULL_TH  = 1,
   localparam int CNTW           = $clog2(DEPTH + 1)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [PUSH_PORTS-1:0]               push,
   input  logic [PUSH_PORTS-1:0][DWIDTH-1:0]   push_data,
   input  logic [POP_PORTS-1:0]                pop,
   output logic [POP_PORTS-1:0][DWIDTH-1:0]    pop_data,
   output logic [POP_PORTS-1:0]                pop_valid,
   output logic                                full,
   output logic                                almost_full,
   output logic                                empty,
   output logic                                almost_empty,
   output logic                                idle,
   output logic [CNTW-1:0]                     count
`ifdef RVV_FIFO_ERR_CHK_EN
   ,
   output logic                                ovf_err,
   output logic                                udf_err,
   output logic                                coding_err
`endif
);

   localparam int PTRW = $clog2(DEPTH);

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]   count_q, count_d;
   logic [CNTW-1:0]   free;
   logic [LCW-1:0]    n_push, n_pop;

   assign free = CNTW'(DEPTH) - count_q;

   rvv_fifo_lane_cnt #(.N(PUSH_PORTS), .LW(CNTW)) u_push_cnt (
      .req_i   (push),
      .limit_i (free),
      .cnt_o   (n_push)
   );

   rvv_fifo_lane_cnt #(.N(POP_PORTS), .LW(CNTW)) u_pop_cnt (
      .req_i   (pop),
      .limit_i (count_q),
      .cnt_o   (n_pop)
   );

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTRW'(n_push);
      rd_ptr_d = rd_ptr_q + PTRW'(n_pop);
      count_d  = count_q + CNTW'(n_push) - CNTW'(n_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage is intentionally left unreset
   always_ff @(posedge clk) begin
      for (int k = 0; k < PUSH_PORTS; k++) begin
         if (LCW'(k) < n_push)
            mem_q[wr_ptr_q + PTRW'(k)] <= push_data[k];
      end
   end

   for (genvar j = 0; j < POP_PORTS; j++) begin : g_rd
      assign pop_data[j]  = mem_q[rd_ptr_q + PTRW'(j)];
      assign pop_valid[j] = (count_q > CNTW'(j));
   end

   assign count        = count_q;
   assign empty        = (count_q == '0);
   assign full         = (count_q == CNTW'(DEPTH));
   assign almost_empty = (int'(count_q) <= ALMOST_EMPTY_TH);
   assign almost_full  = (int'(free) <= ALMOST_FULL_TH);
   assign idle         = empty & ~|push;

`ifdef RVV_FIFO_ERR_CHK_EN
   logic [LCW-1:0] push_req, pop_req;
   logic           push_bad, pop_bad;
   logic           ovf_q, ovf_d;
   logic           udf_q, udf_d;
   logic           cod_q, cod_d;

   assign push_req = thermo_prefix_cnt(MAX_FIFO_PORTS'(push), 16'hFFFF);
   assign pop_req  = thermo_prefix_cnt(MAX_FIFO_PORTS'(pop), 16'hFFFF);
   assign push_bad = ~is_thermo(MAX_FIFO_PORTS'(push));
   assign pop_bad  = ~is_thermo(MAX_FIFO_PORTS'(pop));

   always_comb begin
      ovf_d = ovf_q | (push_req != n_push);
      udf_d = udf_q | (pop_req != n_pop);
      cod_d = cod_q | push_bad | pop_bad;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
         cod_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
         cod_q <= cod_d;
      end
   end

   assign ovf_err    = ovf_q;
   assign udf_err    = udf_q;
   assign coding_err = cod_q;

   always @(posedge clk) begin
      if (rst_n) begin
         assert (push_req == n_push) else $warning("push lane dropped");
         assert (pop_req == n_pop) else $warning("pop lane ignored");
         assert (!(push_bad || pop_bad)) else $warning("non-thermometer request");
      end
   end
`endif

endmodule
